// File: rtl/dat_mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   arb_state_t  : ownership FSM encoding (IDLE, OWN0, OWN1)
//   ADDR_W/DATA_W: data memory geometry (8-bit address, 8-bit data)
//   PROT_LO_DEF/PROT_HI_DEF: default bounds of the write-protected mask table,
//                 used when DAT_MEM_WRPROT_EN is defined.
package dat_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 8;
    localparam int PROT_LO_DEF = 60;
    localparam int PROT_HI_DEF = 68;

endpackage

// File: rtl/dat_mem_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-way round-robin chooser.
//   req[1:0] in  : pending requests
//   last     in  : port that owned the memory most recently
//   winner   out : chosen port index; only meaningful when |req
// On a tie the port that did not go last wins; a lone requester always wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);

    assign winner = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/dat_mem_arbiter.sv
// dat_mem_arbiter: shares the single-port 256x8 data memory between port 0
// (core load/store) and port 1 (loader/DMA) with round-robin ownership and a
// bounded burst of MAX_BURST granted accesses per ownership.
//
// Handshake: a port raises req[i] with we/addr/wdat stable and holds them
// until the cycle in which gnt[i] is high; that cycle is the access. A read's
// data appears on rdat_i with rvalid[i] high for exactly the following cycle.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req, we             per-port request / write-not-read
//   addr0/1, wdat0/1    per-port address and write data
//   gnt                 combinational grant (one-hot or zero)
//   rdat0/1, rvalid     registered read return
//   mem_wr_en/addr/din  memory drive (all zero when nothing is granted)
//   mem_dout            combinational memory read data
//   prot_err            (DAT_MEM_WRPROT_EN only) pulses the cycle after a
//                       blocked write into PROT_LO..PROT_HI
//   state_dbg           current ownership state
//
// Optional feature macro: DAT_MEM_WRPROT_EN (write protection of the mask table).
module dat_mem_arbiter
    import dat_mem_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
`ifdef DAT_MEM_WRPROT_EN
    ,
    parameter int PROT_LO   = PROT_LO_DEF,
    parameter int PROT_HI   = PROT_HI_DEF
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdat0,
    input  logic [DATA_W-1:0] wdat1,
    output logic [1:0]        gnt,
    output logic [DATA_W-1:0] rdat0,
    output logic [DATA_W-1:0] rdat1,
    output logic [1:0]        rvalid,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
`ifdef DAT_MEM_WRPROT_EN
    output logic              prot_err,
`endif
    output logic [1:0]        state_dbg
);

    localparam int CNT_W = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t       state, state_nxt;
    logic             last, last_nxt;
    logic [CNT_W-1:0] burst_cnt, burst_nxt;

    logic pick;
    logic own_sel;
    logic own_req;
    logic other_req;
    logic any_gnt;
    logic sel;
    logic wr_req;
    logic wr_blocked;

    rr_pick2 u_pick (
        .req    (req),
        .last   (last),
        .winner (pick)
    );

    // Owner-relative views of the request lines, valid in OWN0/OWN1.
    assign own_sel   = (state == OWN1);
    assign own_req   = own_sel ? req[1] : req[0];
    assign other_req = own_sel ? req[0] : req[1];

    assign gnt[0] = (state == OWN0) & req[0];
    assign gnt[1] = (state == OWN1) & req[1];

    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        burst_nxt = burst_cnt;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = pick ? OWN1 : OWN0;
                    burst_nxt = '0;
                end
            end
            OWN0, OWN1: begin
                if (!own_req) begin
                    // Owner released: hand straight to a waiting port, else idle.
                    last_nxt  = own_sel;
                    burst_nxt = '0;
                    if (other_req) state_nxt = own_sel ? OWN0 : OWN1;
                    else           state_nxt = IDLE;
                end else if (burst_cnt == BURST_LAST) begin
                    // Burst exhausted on this grant. A lone requester keeps the
                    // memory and simply starts a fresh burst.
                    burst_nxt = '0;
                    if (other_req) begin
                        last_nxt  = own_sel;
                        state_nxt = own_sel ? OWN0 : OWN1;
                    end
                end else begin
                    burst_nxt = burst_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                burst_nxt = '0;
            end
        endcase
    end

    // Memory drive from the granted port; everything is zero without a grant.
    assign any_gnt  = |gnt;
    assign sel      = gnt[1];
    assign mem_addr = any_gnt ? (sel ? addr1 : addr0) : '0;
    assign mem_din  = any_gnt ? (sel ? wdat1 : wdat0) : '0;
    assign wr_req   = any_gnt & (sel ? we[1] : we[0]);

`ifdef DAT_MEM_WRPROT_EN
    localparam logic [ADDR_W-1:0] PLO = ADDR_W'(PROT_LO);
    localparam logic [ADDR_W-1:0] PHI = ADDR_W'(PROT_HI);

    assign wr_blocked = wr_req & (mem_addr >= PLO) & (mem_addr <= PHI);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prot_err <= 1'b0;
        else       prot_err <= wr_blocked;
    end
`else
    assign wr_blocked = 1'b0;
`endif

    assign mem_wr_en = wr_req & ~wr_blocked;

    // Read return: capture the memory output at the granted edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdat0  <= '0;
            rdat1  <= '0;
            rvalid <= 2'b00;
        end else begin
            rvalid[0] <= gnt[0] & ~we[0];
            rvalid[1] <= gnt[1] & ~we[1];
            if (gnt[0] & ~we[0]) rdat0 <= mem_dout;
            if (gnt[1] & ~we[1]) rdat1 <= mem_dout;
        end
    end

endmodule
